fu_pipe: RTL and testbench
==========================

Name: fu_pipe

Overview:
- Parametrised multi-cycle pipelined functional unit. Successor to the single-cycle simple-ALU FU.
- Executes integer multiply ops over LATENCY stages. Tracks each in-flight instruction's branch mask at every stage: kills on mispredict, clears the resolved bit on correct verification.
- Adds a valid/ready back-pressure handshake toward writeback.
- Sits between the issue/regread stage and the writeback/bypass network.

Parameters:
- LATENCY, 3, pipeline depth in cycles from input accept to output valid (≥1).
- DATA_W, 32, operand/result width.
- CHECKPOINTS, 4, branch-mask width (one bit per checkpoint).
- CHECKPOINTS_LOG, 2, width of checkpoint id.
- TAG_W, 20, opaque payload width {destReg, ALid, IQentry}, carried unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inValid_i  in  1  input op valid
- inReady_o  out  1  unit can accept this cycle
- inOpcode_i  in  2  00 MULLO, 01 MULH signed×signed, 10 MULHU unsigned×unsigned, 11 MULHSU signed×unsigned
- inData1_i  in  DATA_W  operand A
- inData2_i  in  DATA_W  operand B
- inMask_i  in  CHECKPOINTS  branch mask of op
- inTag_i  in  TAG_W  payload
- ctrlVerified_i  in  1  branch resolved this cycle
- ctrlMispredict_i  in  1  resolved branch mispredicted
- ctrlSMTid_i  in  CHECKPOINTS_LOG  checkpoint of resolved branch
- outValid_o  out  1  result valid
- outReady_i  in  1  downstream accepts
- outResult_o  out  DATA_W  result
- outMask_o  out  CHECKPOINTS  current branch mask
- outTag_o  out  TAG_W  payload

Behaviour:
- Pipeline of LATENCY register stages, each holding {valid, opcode/partial product, mask, tag}.
- advance = !stgValid[LAST] | outReady_i. All stages shift together when advance=1; all hold when advance=0.
- inReady_o = advance, combinational. Input captured only when inValid_i & inReady_o.
- Bubbles are not collapsed in v1. Fixed latency of LATENCY cycles when no back-pressure.
- Arithmetic:
  - Full 2·DATA_W product.
  - MULLO returns low DATA_W; other ops return high DATA_W.
  - Signedness per opcode; MULHSU treats A signed, B unsigned.
  - The product may be retimed across stages; only final-stage correctness is required.
- Define kill = ctrlVerified_i & ctrlMispredict_i, and clr = ctrlVerified_i & !ctrlMispredict_i.
- Kill:
  - Every stage with mask[ctrlSMTid_i]=1 has its valid cleared at the clock edge.
  - The incoming op is filtered the same way: it is not captured if inMask_i[ctrlSMTid_i]=1.
  - outValid_o is combinationally forced to 0 in the kill cycle if the last-stage mask bit is set.
- Clear:
  - Bit ctrlSMTid_i is cleared in every stage mask at the edge.
  - It is cleared in the incoming mask on capture.
  - outMask_o shows the bit cleared combinationally in the same cycle.
- Kill/clear apply whether or not the pipe is stalled. A stalled killed entry becomes a bubble, and advance recomputes next cycle.
- Simultaneous accept-out and kill of the last stage: entry dropped, no handshake counted.
- Reset: all stage valids=0; outValid_o=0. Masks, tags and data are don't-care. inReady_o=1 the cycle after reset deasserts. Reset mid-operation discards all in-flight ops.
- With outReady_i tied high, throughput is 1 op/cycle.

Optional Feature:
- Macro FU_PIPE_PERF_EN.
- When defined, adds outputs perfIssued_o, perfKilled_o and perfStallCyc_o (each 32 bits, wrap at 2^32, reset to 0):
  - perfIssued_o counts accepted ops.
  - perfKilled_o counts killed entries (pipeline stages plus filtered input).
  - perfStallCyc_o counts cycles with stgValid[LAST] & !outReady_i.
- When undefined: ports and counters absent, no behavioural difference.

Decomposition:
- Shared package: opcode enum (MULLO/MULH/MULHU/MULHSU), EXECUTION_FLAGS-free result struct, and the mask-update helper function (kill test and bit clear).
- One sub-module: fu_pipe_stage. A single register stage with valid, mask update (kill/clr), hold-on-stall. It is instantiated LATENCY times via generate.

Test Plan:
1. LATENCY=3, outReady_i=1: issue MULLO 7×6 at cycle 0 → outValid_o=1 at cycle 3, outResult_o=42, tag unchanged.
2. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
3. Three ops with masks 0001, 0010, 0011 in flight; mispredict on id 0 → only the 0010 op emerges; perfKilled_o=2 if enabled.
4. Op with mask 0100 in stage 1; correct verify of id 2 → outMask_o=0000 on exit.
5. Hold outReady_i=0 for 4 cycles with a full pipe → inReady_o=0, outputs stable. Release → 3 results in consecutive cycles, no loss or duplication.
6. Assert reset while 3 ops are in flight → outValid_o=0 next cycle, and no stale results afterwards.

Source files
------------

// File: rtl/fu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fu_pipe_pkg
// Shared types and helpers for the pipelined multiply functional unit.
//   fu_op_e     : multiply opcode (low half / signed-high / unsigned-high /
//                 signed-by-unsigned-high)
//   fu_ctrl_t   : branch-resolution command broadcast to every pipe stage
//   mask_hit    : does a branch mask depend on a given checkpoint
//   mask_clear  : drop a resolved checkpoint from a branch mask
// Masks are handled at MASK_MAX bits inside the helpers so one definition
// serves every CHECKPOINTS setting up to 32; callers zero-extend on the way
// in and truncate on the way out.
// -----------------------------------------------------------------------------
package fu_pipe_pkg;

    localparam int MASK_MAX  = 32;
    localparam int MASK_ID_W = 5;

    typedef enum logic [1:0] {
        OP_MULLO  = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHU  = 2'b10,
        OP_MULHSU = 2'b11
    } fu_op_e;

    typedef struct packed {
        logic                 kill;  // resolved branch mispredicted
        logic                 clr;   // resolved branch was correct
        logic [MASK_ID_W-1:0] id;    // checkpoint of the resolved branch
    } fu_ctrl_t;

    function automatic logic mask_hit(input logic [MASK_MAX-1:0]  mask,
                                      input logic [MASK_ID_W-1:0] id);
        logic [MASK_MAX-1:0] sel;
        sel = MASK_MAX'(1) << id;
        return |(mask & sel);
    endfunction

    function automatic logic [MASK_MAX-1:0] mask_clear(input logic [MASK_MAX-1:0]  mask,
                                                       input logic [MASK_ID_W-1:0] id);
        logic [MASK_MAX-1:0] sel;
        sel = MASK_MAX'(1) << id;
        return mask & ~sel;
    endfunction

endpackage

// File: rtl/fu_pipe_if.sv
// -----------------------------------------------------------------------------
// fu_pipe_if
// Issue-side and writeback-side signals of the multiply unit, plus the branch
// resolution broadcast.
//   Handshake (both sides): a transfer happens in a cycle where valid and
//   ready are both high. Valid never depends on ready from the same side.
//   The unit's inReady_o is combinational from its own last-stage state and
//   outReady_i; the payload must be held stable while valid is high and
//   ready is low.
// Modports:
//   slave  : the functional unit's view
//   master : the issuing / writeback environment's view
// -----------------------------------------------------------------------------
interface fu_pipe_if #(
    parameter int DATA_W          = 32,
    parameter int CHECKPOINTS     = 4,
    parameter int CHECKPOINTS_LOG = 2,
    parameter int TAG_W           = 20
);
    logic                       inValid_i;
    logic                       inReady_o;
    logic [1:0]                 inOpcode_i;
    logic [DATA_W-1:0]          inData1_i;
    logic [DATA_W-1:0]          inData2_i;
    logic [CHECKPOINTS-1:0]     inMask_i;
    logic [TAG_W-1:0]           inTag_i;
    logic                       ctrlVerified_i;
    logic                       ctrlMispredict_i;
    logic [CHECKPOINTS_LOG-1:0] ctrlSMTid_i;
    logic                       outValid_o;
    logic                       outReady_i;
    logic [DATA_W-1:0]          outResult_o;
    logic [CHECKPOINTS-1:0]     outMask_o;
    logic [TAG_W-1:0]           outTag_o;

    modport slave (
        input  inValid_i, inOpcode_i, inData1_i, inData2_i, inMask_i, inTag_i,
               ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i, outReady_i,
        output inReady_o, outValid_o, outResult_o, outMask_o, outTag_o
    );

    modport master (
        output inValid_i, inOpcode_i, inData1_i, inData2_i, inMask_i, inTag_i,
               ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i, outReady_i,
        input  inReady_o, outValid_o, outResult_o, outMask_o, outTag_o
    );
endinterface

// File: rtl/fu_pipe_stage.sv
// -----------------------------------------------------------------------------
// fu_pipe_stage
// One register stage of the multiply pipe: valid bit, branch mask and an
// opaque payload. On advance it loads the upstream entry, otherwise it holds
// its own. Kill/clear from the branch unit are applied to whichever entry
// lands in the register, so a killed entry becomes a bubble even while the
// pipe is stalled, and an upstream entry killed this cycle never arrives.
// Ports:
//   clk, reset        clock, synchronous active-high reset (clears valid)
//   advance_i         shift enable shared by all stages
//   ctrl_i            branch resolution command
//   valid_i/mask_i/payload_i   upstream entry
//   valid_o/mask_o/payload_o   registered entry
// -----------------------------------------------------------------------------
module fu_pipe_stage
    import fu_pipe_pkg::*;
#(
    parameter int CHECKPOINTS = 4,
    parameter int PAYLOAD_W   = 52
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   advance_i,
    input  fu_ctrl_t               ctrl_i,
    input  logic                   valid_i,
    input  logic [CHECKPOINTS-1:0] mask_i,
    input  logic [PAYLOAD_W-1:0]   payload_i,
    output logic                   valid_o,
    output logic [CHECKPOINTS-1:0] mask_o,
    output logic [PAYLOAD_W-1:0]   payload_o
);
    logic                   valid_q, valid_d;
    logic [CHECKPOINTS-1:0] mask_q, mask_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic                   src_valid;
    logic [CHECKPOINTS-1:0] src_mask;

    always_comb begin
        src_valid = advance_i ? valid_i : valid_q;
        src_mask  = advance_i ? mask_i  : mask_q;
        payload_d = advance_i ? payload_i : payload_q;
        valid_d   = src_valid & ~(ctrl_i.kill & mask_hit(MASK_MAX'(src_mask), ctrl_i.id));
        mask_d    = ctrl_i.clr ? CHECKPOINTS'(mask_clear(MASK_MAX'(src_mask), ctrl_i.id))
                               : src_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Mask and payload are meaningless while valid is low, so no reset.
    always_ff @(posedge clk) begin
        mask_q    <= mask_d;
        payload_q <= payload_d;
    end

    assign valid_o   = valid_q;
    assign mask_o    = mask_q;
    assign payload_o = payload_q;
endmodule

// File: rtl/fu_pipe.sv
// -----------------------------------------------------------------------------
// fu_pipe
// Multi-cycle pipelined integer multiplier with branch-mask tracking and
// valid/ready back-pressure toward writeback. The full 2*DATA_W product is
// formed at issue and the selected half rides the pipe with the tag.
// Ports:
//   clk, reset   clock, synchronous active-high reset (drops all in-flight ops)
//   bus          fu_pipe_if.slave: issue handshake, operands, mask, tag,
//                branch resolution, writeback handshake and result
// Optional (macro FU_PIPE_PERF_EN):
//   perfIssued_o   accepted ops
//   perfKilled_o   entries killed (pipe stages plus filtered input)
//   perfStallCyc_o cycles with a result waiting and writeback not ready
// -----------------------------------------------------------------------------
module fu_pipe
    import fu_pipe_pkg::*;
#(
    parameter int LATENCY         = 3,
    parameter int DATA_W          = 32,
    parameter int CHECKPOINTS     = 4,
    parameter int CHECKPOINTS_LOG = 2,
    parameter int TAG_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    fu_pipe_if.slave    bus
`ifdef FU_PIPE_PERF_EN
    ,
    output logic [31:0] perfIssued_o,
    output logic [31:0] perfKilled_o,
    output logic [31:0] perfStallCyc_o
`endif
);
    localparam int LAST = LATENCY - 1;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tag;
    } fu_result_t;

    localparam int PAYLOAD_W = $bits(fu_result_t);

    fu_ctrl_t               ctrl;
    logic                   advance;
    logic                   stg_valid   [LATENCY];
    logic [CHECKPOINTS-1:0] stg_mask    [LATENCY];
    fu_result_t             stg_payload [LATENCY];
    fu_result_t             in_payload;
    logic                   a_signed, b_signed;
    logic [2*DATA_W-1:0]    a_ext, b_ext, product;

    always_comb begin
        ctrl.kill = bus.ctrlVerified_i & bus.ctrlMispredict_i;
        ctrl.clr  = bus.ctrlVerified_i & ~bus.ctrlMispredict_i;
        ctrl.id   = MASK_ID_W'(bus.ctrlSMTid_i);
    end

    // Bubbles are not squeezed out: the whole pipe moves or the whole pipe holds.
    assign advance       = ~stg_valid[LAST] | bus.outReady_i;
    assign bus.inReady_o = advance;

    // Extending both operands to 2*DATA_W according to their signedness makes
    // the low 2*DATA_W bits of a plain multiply correct for every opcode.
    always_comb begin
        a_signed = (bus.inOpcode_i == OP_MULH) || (bus.inOpcode_i == OP_MULHSU);
        b_signed = (bus.inOpcode_i == OP_MULH);
        a_ext    = {{DATA_W{a_signed & bus.inData1_i[DATA_W-1]}}, bus.inData1_i};
        b_ext    = {{DATA_W{b_signed & bus.inData2_i[DATA_W-1]}}, bus.inData2_i};
        product  = a_ext * b_ext;
        in_payload.result = (bus.inOpcode_i == OP_MULLO) ? product[DATA_W-1:0]
                                                         : product[2*DATA_W-1:DATA_W];
        in_payload.tag    = bus.inTag_i;
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        if (g == 0) begin : g_first
            fu_pipe_stage #(.CHECKPOINTS(CHECKPOINTS), .PAYLOAD_W(PAYLOAD_W)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .advance_i (advance),
                .ctrl_i    (ctrl),
                .valid_i   (bus.inValid_i),
                .mask_i    (bus.inMask_i),
                .payload_i (in_payload),
                .valid_o   (stg_valid[g]),
                .mask_o    (stg_mask[g]),
                .payload_o (stg_payload[g])
            );
        end else begin : g_next
            fu_pipe_stage #(.CHECKPOINTS(CHECKPOINTS), .PAYLOAD_W(PAYLOAD_W)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .advance_i (advance),
                .ctrl_i    (ctrl),
                .valid_i   (stg_valid[g-1]),
                .mask_i    (stg_mask[g-1]),
                .payload_i (stg_payload[g-1]),
                .valid_o   (stg_valid[g]),
                .mask_o    (stg_mask[g]),
                .payload_o (stg_payload[g])
            );
        end
    end

    // Resolution is visible on the output in the same cycle: a killed result
    // is withheld and a correctly-resolved bit is already gone from the mask.
    assign bus.outValid_o  = stg_valid[LAST]
                           & ~(ctrl.kill & mask_hit(MASK_MAX'(stg_mask[LAST]), ctrl.id));
    assign bus.outMask_o   = ctrl.clr ? CHECKPOINTS'(mask_clear(MASK_MAX'(stg_mask[LAST]), ctrl.id))
                                      : stg_mask[LAST];
    assign bus.outResult_o = stg_payload[LAST].result;
    assign bus.outTag_o    = stg_payload[LAST].tag;

`ifdef FU_PIPE_PERF_EN
    logic [31:0] issued_q, killed_q, stall_q;
    logic [31:0] kill_cnt;

    always_comb begin
        kill_cnt = 32'(bus.inValid_i & advance & ctrl.kill
                       & mask_hit(MASK_MAX'(bus.inMask_i), ctrl.id));
        for (int i = 0; i < LATENCY; i++) begin
            kill_cnt = kill_cnt + 32'(stg_valid[i] & ctrl.kill
                                      & mask_hit(MASK_MAX'(stg_mask[i]), ctrl.id));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
            killed_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_q + 32'(bus.inValid_i & advance);
            killed_q <= killed_q + kill_cnt;
            stall_q  <= stall_q + 32'(stg_valid[LAST] & ~bus.outReady_i);
        end
    end

    assign perfIssued_o   = issued_q;
    assign perfKilled_o   = killed_q;
    assign perfStallCyc_o = stall_q;
`endif
endmodule

// File: tb/tb_fu_pipe.sv
// -----------------------------------------------------------------------------
// tb_fu_pipe
// Self-checking bench for fu_pipe (LATENCY=3, DATA_W=32, 4 checkpoints).
// Directed scenarios followed by a randomized run against an in-order
// expected-result queue. Counter checks are compiled in with FU_PIPE_PERF_EN.
// -----------------------------------------------------------------------------
module tb_fu_pipe;
    localparam int LATENCY = 3;
    localparam int DATA_W  = 32;
    localparam int CP      = 4;
    localparam int CPL     = 2;
    localparam int TAG_W   = 20;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fu_pipe_if #(.DATA_W(DATA_W), .CHECKPOINTS(CP), .CHECKPOINTS_LOG(CPL), .TAG_W(TAG_W)) bus();

`ifdef FU_PIPE_PERF_EN
    logic [31:0] perf_issued, perf_killed, perf_stall;
`endif

    fu_pipe #(.LATENCY(LATENCY), .DATA_W(DATA_W), .CHECKPOINTS(CP),
              .CHECKPOINTS_LOG(CPL), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FU_PIPE_PERF_EN
        ,
        .perfIssued_o   (perf_issued),
        .perfKilled_o   (perf_killed),
        .perfStallCyc_o (perf_stall)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0:    p = ua * ub;
            2'd1:    p = sa * sb;
            2'd2:    p = ua * ub;
            default: p = sa * longint'(ub);
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.inValid_i        = 1'b0;
        bus.inOpcode_i       = 2'd0;
        bus.inData1_i        = '0;
        bus.inData2_i        = '0;
        bus.inMask_i         = '0;
        bus.inTag_i          = '0;
        bus.ctrlVerified_i   = 1'b0;
        bus.ctrlMispredict_i = 1'b0;
        bus.ctrlSMTid_i      = '0;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] mask, input logic [19:0] tag);
        bus.inValid_i  = 1'b1;
        bus.inOpcode_i = op;
        bus.inData1_i  = a;
        bus.inData2_i  = b;
        bus.inMask_i   = mask;
        bus.inTag_i    = tag;
    endtask

    task automatic drive_ctrl(input logic verified, input logic mispredict, input logic [1:0] id);
        bus.ctrlVerified_i   = verified;
        bus.ctrlMispredict_i = mispredict;
        bus.ctrlSMTid_i      = id;
    endtask

    // Inputs change just after the rising edge; outputs are read at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.outReady_i = 1'b1;
        repeat (3) begin
            next_cycle();
            settle();
            n_checks++;
            if (bus.outValid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_out_valid: got %b exp 0", bus.outValid_o);
            end
        end
        next_cycle();
        reset = 1'b0;
        bus.outReady_i = 1'b0;
        next_cycle();
        settle();
        n_checks++;
        if (bus.inReady_o !== 1'b1 || bus.outValid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_ready: got ready=%b valid=%b exp ready=1 valid=0",
                     bus.inReady_o, bus.outValid_o);
        end
        bus.outReady_i = 1'b1;
    endtask

    task automatic test_latency();
        for (int c = 0; c <= LATENCY + 1; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 0) drive_op(2'd0, 32'd7, 32'd6, 4'b0000, 20'h12345);
            settle();
            n_checks++;
            if (c == LATENCY) begin
                if (bus.outValid_o !== 1'b1 || bus.outResult_o !== 32'd42 ||
                    bus.outTag_o !== 20'h12345 || bus.outMask_o !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL mullo_latency: got v=%b res=%h tag=%h mask=%b exp v=1 res=2a tag=12345 mask=0000",
                             bus.outValid_o, bus.outResult_o, bus.outTag_o, bus.outMask_o);
                end
            end else if (bus.outValid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL mullo_timing c%0d: got valid=%b exp 0", c, bus.outValid_o);
            end
        end
    endtask

    task automatic test_mul_ops();
        logic [1:0]  ops   [3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] opb   [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
        logic [31:0] exp_r [3] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int c = 0; c < LATENCY + 3; c++) begin
            next_cycle();
            idle_inputs();
            if (c < 3) drive_op(ops[c], 32'hFFFFFFFF, opb[c], 4'b0000, 20'(20'h50 + c));
            settle();
            n_checks++;
            if (c >= LATENCY) begin
                if (bus.outValid_o !== 1'b1 || bus.outResult_o !== exp_r[c-LATENCY] ||
                    bus.outTag_o !== 20'(20'h50 + c - LATENCY)) begin
                    n_errors++;
                    $display("FAIL mul_op%0d: got v=%b res=%h tag=%h exp v=1 res=%h tag=%h",
                             c - LATENCY, bus.outValid_o, bus.outResult_o, bus.outTag_o,
                             exp_r[c-LATENCY], 20'(20'h50 + c - LATENCY));
                end
            end else if (bus.outValid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL mul_ops_early c%0d: got valid=%b exp 0", c, bus.outValid_o);
            end
        end
    endtask

    task automatic test_kill();
        logic [3:0]  masks [3] = '{4'b0001, 4'b0010, 4'b0011};
        logic [31:0] k0 = 32'd0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            idle_inputs();
            drive_op(2'd0, 32'(c + 1), 32'd3, masks[c], 20'(20'h100 + c));
            settle();
        end
        next_cycle();
        idle_inputs();
        drive_ctrl(1'b1, 1'b1, 2'd0);
        settle();
`ifdef FU_PIPE_PERF_EN
        k0 = perf_killed;
`endif
        n_checks++;
        if (bus.outValid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL kill_forced_invalid: got valid=%b exp 0", bus.outValid_o);
        end
        next_cycle();
        idle_inputs();
        settle();
        n_checks++;
        if (bus.outValid_o !== 1'b1 || bus.outTag_o !== 20'h101 ||
            bus.outMask_o !== 4'b0010 || bus.outResult_o !== 32'd6) begin
            n_errors++;
            $display("FAIL kill_survivor: got v=%b tag=%h mask=%b res=%h exp v=1 tag=101 mask=0010 res=6",
                     bus.outValid_o, bus.outTag_o, bus.outMask_o, bus.outResult_o);
        end
`ifdef FU_PIPE_PERF_EN
        n_checks++;
        if (perf_killed - k0 !== 32'd2) begin
            n_errors++;
            $display("FAIL perf_killed: got %0d exp 2", perf_killed - k0);
        end
`endif
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            settle();
            n_checks++;
            if (bus.outValid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL kill_no_extra c%0d: got valid=%b exp 0", c, bus.outValid_o);
            end
        end
        if (k0 == 32'hFFFF_FFFF) $display("note: killed counter near wrap");
    endtask

    task automatic test_clear();
        next_cycle();
        idle_inputs();
        drive_op(2'd0, 32'd5, 32'd5, 4'b0100, 20'h200);
        settle();
        next_cycle();
        idle_inputs();
        drive_op(2'd0, 32'd4, 32'd4, 4'b1000, 20'h201);
        drive_ctrl(1'b1, 1'b0, 2'd2);
        settle();
        next_cycle();
        idle_inputs();
        settle();
        next_cycle();
        settle();
        n_checks++;
        if (bus.outValid_o !== 1'b1 || bus.outMask_o !== 4'b0000 ||
            bus.outTag_o !== 20'h200 || bus.outResult_o !== 32'd25) begin
            n_errors++;
            $display("FAIL clear_staged: got v=%b mask=%b tag=%h res=%h exp v=1 mask=0000 tag=200 res=19",
                     bus.outValid_o, bus.outMask_o, bus.outTag_o, bus.outResult_o);
        end
        next_cycle();
        drive_ctrl(1'b1, 1'b0, 2'd3);
        settle();
        n_checks++;
        if (bus.outValid_o !== 1'b1 || bus.outMask_o !== 4'b0000 || bus.outTag_o !== 20'h201) begin
            n_errors++;
            $display("FAIL clear_comb: got v=%b mask=%b tag=%h exp v=1 mask=0000 tag=201",
                     bus.outValid_o, bus.outMask_o, bus.outTag_o);
        end
        next_cycle();
        idle_inputs();
        settle();
        n_checks++;
        if (bus.outValid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_no_extra: got valid=%b exp 0", bus.outValid_o);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] s0 = 32'd0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            idle_inputs();
            drive_op(2'd0, 32'(c + 2), 32'(c + 9), 4'b0000, 20'(20'h300 + c));
            settle();
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            bus.outReady_i = 1'b0;
            drive_op(2'd0, 32'd1, 32'd1, 4'b0000, 20'h3FF);
            settle();
`ifdef FU_PIPE_PERF_EN
            if (c == 0) s0 = perf_stall;
`endif
            n_checks++;
            if (bus.inReady_o !== 1'b0 || bus.outValid_o !== 1'b1 ||
                bus.outTag_o !== 20'h300 || bus.outResult_o !== 32'd18) begin
                n_errors++;
                $display("FAIL stall_hold c%0d: got rdy=%b v=%b tag=%h res=%h exp rdy=0 v=1 tag=300 res=12",
                         c, bus.inReady_o, bus.outValid_o, bus.outTag_o, bus.outResult_o);
            end
        end
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            idle_inputs();
            bus.outReady_i = 1'b1;
            settle();
`ifdef FU_PIPE_PERF_EN
            if (c == 0) begin
                n_checks++;
                if (perf_stall - s0 !== 32'd4) begin
                    n_errors++;
                    $display("FAIL perf_stall: got %0d exp 4", perf_stall - s0);
                end
            end
`endif
            n_checks++;
            if (c < 3) begin
                if (bus.outValid_o !== 1'b1 || bus.outTag_o !== 20'(20'h300 + c) ||
                    bus.outResult_o !== 32'((c + 2) * (c + 9)) || bus.inReady_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL release_r%0d: got v=%b tag=%h res=%h rdy=%b exp v=1 tag=%h res=%h rdy=1",
                             c, bus.outValid_o, bus.outTag_o, bus.outResult_o, bus.inReady_o,
                             20'(20'h300 + c), 32'((c + 2) * (c + 9)));
                end
            end else if (bus.outValid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL release_extra c%0d: got valid=%b tag=%h exp valid=0",
                         c, bus.outValid_o, bus.outTag_o);
            end
        end
        if (s0 == 32'hFFFF_FFFF) $display("note: stall counter near wrap");
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            idle_inputs();
            drive_op(2'd0, 32'd3, 32'(c), 4'b0000, 20'(20'h400 + c));
            settle();
        end
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        settle();
        next_cycle();
        reset = 1'b0;
        settle();
        n_checks++;
        if (bus.outValid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_valid: got %b exp 0", bus.outValid_o);
        end
        for (int c = 0; c < LATENCY + 2; c++) begin
            next_cycle();
            settle();
            n_checks++;
            if (bus.outValid_o !== 1'b0 || bus.inReady_o !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_mid_stale c%0d: got v=%b rdy=%b tag=%h exp v=0 rdy=1",
                         c, bus.outValid_o, bus.inReady_o, bus.outTag_o);
            end
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [3:0]  mask;
        logic [19:0] tag;
        int          issue_cyc;
    } ent_t;

    task automatic test_random();
        ent_t        exp_q[$];
        ent_t        keep_q[$];
        ent_t        e;
        int          n_acc = 0;
        int          id;
        logic        kill, clr;
        logic [31:0] i0 = 32'd0;
`ifdef FU_PIPE_PERF_EN
        i0 = perf_issued;
`endif
        for (int c = 0; c < 3000 + LATENCY + 4; c++) begin
            next_cycle();
            idle_inputs();
            if (c < 3000) begin
                if ($urandom_range(0, 99) < 60)
                    drive_op(2'($urandom_range(0, 3)), $urandom, $urandom,
                             4'($urandom_range(0, 15)), 20'($urandom));
                if ($urandom_range(0, 99) < 12)
                    drive_ctrl(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                bus.outReady_i = ($urandom_range(0, 99) < 70);
            end else begin
                bus.outReady_i = 1'b1;
            end
            settle();
            kill = bus.ctrlVerified_i & bus.ctrlMispredict_i;
            clr  = bus.ctrlVerified_i & ~bus.ctrlMispredict_i;
            id   = int'(bus.ctrlSMTid_i);
            if (kill) begin
                keep_q.delete();
                foreach (exp_q[i]) if (!exp_q[i].mask[id]) keep_q.push_back(exp_q[i]);
                exp_q = keep_q;
            end
            if (clr) begin
                foreach (exp_q[i]) begin
                    e = exp_q[i];
                    e.mask[id] = 1'b0;
                    exp_q[i] = e;
                end
            end
            if (bus.outReady_i) begin
                n_checks++;
                if (bus.inReady_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rand_ready c%0d: got %b exp 1", c, bus.inReady_o);
                end
            end
            if (bus.outValid_o === 1'b1 && bus.outReady_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rand_spurious c%0d: got tag=%h exp no result", c, bus.outTag_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.outResult_o !== e.res || bus.outTag_o !== e.tag ||
                        bus.outMask_o !== e.mask || (cyc - e.issue_cyc) < LATENCY) begin
                        n_errors++;
                        $display("FAIL rand_result c%0d: got res=%h tag=%h mask=%b lat=%0d exp res=%h tag=%h mask=%b lat>=%0d",
                                 c, bus.outResult_o, bus.outTag_o, bus.outMask_o, cyc - e.issue_cyc,
                                 e.res, e.tag, e.mask, LATENCY);
                    end
                end
            end
            if (bus.inValid_i && bus.inReady_o === 1'b1) begin
                n_acc++;
                if (!(kill && bus.inMask_i[id])) begin
                    e.res       = ref_mul(bus.inOpcode_i, bus.inData1_i, bus.inData2_i);
                    e.mask      = bus.inMask_i;
                    if (clr) e.mask[id] = 1'b0;
                    e.tag       = bus.inTag_i;
                    e.issue_cyc = cyc;
                    exp_q.push_back(e);
                end
            end
            if (exp_q.size() > LATENCY) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand_occupancy c%0d: got %0d exp <=%0d", c, exp_q.size(), LATENCY);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rand_drain: got %0d left exp 0", exp_q.size());
        end
`ifdef FU_PIPE_PERF_EN
        n_checks++;
        if (perf_issued - i0 !== 32'(n_acc)) begin
            n_errors++;
            $display("FAIL perf_issued: got %0d exp %0d", perf_issued - i0, n_acc);
        end
`endif
        if (i0 == 32'hFFFF_FFFF) $display("note: issued counter near wrap");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        bus.outReady_i = 1'b1;
        test_reset();
        test_latency();
        test_mul_ops();
        test_kill();
        test_clear();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
